cam_emu: RTL and testbench

Camera-side transmitter for the OV7670 capture path. It generates a self-contained QQVGA-style frame stream on one clock: `vsync`, `href` and byte-serial RGB565 `px_data`. The stream comes from an internal test pattern. It drives the capture front-end and frame buffer on the FPGA without a physical sensor, and serves as the stimulus source for capture regression.

---
 rtl/cam_emu_if.sv | 8 +
 rtl/cam_emu.sv | 118 +++++++++++
 tb/tb_cam_emu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cam_emu_if.sv
// cam_emu_if: OV7670-style video bus carrying vsync, href and byte-serial pixel data.
interface cam_emu_if;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  modport master (output vsync, href, px_data);
  modport slave  (input  vsync, href, px_data);
endinterface

// File: rtl/cam_emu.sv
// cam_emu: test-pattern OV7670 frame generator driving vsync/href/RGB565 bytes on one clock.
module cam_emu #(
  parameter int H_PX      = 160,
  parameter int V_LN      = 120,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 2,
  parameter int H_BLANK   = 16
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   pattern,
  input  logic [15:0]  solid_rgb,
  cam_emu_if.master    vid,
  output logic         busy,
  output logic         frame_done,
  output logic [7:0]   frame_cnt
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  localparam int LINE_LEN = 2*H_PX + H_BLANK;
  localparam int HW = $clog2(LINE_LEN);
  localparam int LW = $clog2(V_LN + VS_LINES + VBP_LINES + VFP_LINES + 1);
  localparam int BAR_W = H_PX/8;
  localparam int BW = $clog2(BAR_W + 1);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  state_t state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [LW-1:0] ln_q, ln_d, n_lines;
  logic [BW-1:0] bpx_q, bpx_d;
  logic [2:0]    bar_q, bar_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d, rgb;
  logic          vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]    px_q, px_d, cnt_q, cnt_d;
  logic          line_end, last_ln;
  logic [4:0]    x5;
  logic [5:0]    y6;
  // Outputs are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    line_end = h_q == HW'(LINE_LEN-1);
    n_lines  = state_q == VSYNC ? LW'(VS_LINES) : state_q == VBP ? LW'(VBP_LINES) :
               state_q == ACTIVE ? LW'(V_LN) : LW'(VFP_LINES);
    last_ln  = line_end && ln_q == n_lines - LW'(1);
    x5       = 5'(h_q >> 1);
    y6       = 6'(ln_q);
    rgb      = pat_q == 2'd0 ? BARS[bar_q] :
               pat_q == 2'd1 ? {x5, y6, x5 + y6[4:0]} :
               pat_q == 2'd2 ? solid_q : {16{x5[3] ^ y6[3]}};
    state_d  = state_q;
    pat_d    = pat_q;
    solid_d  = solid_q;
    h_d      = (state_q == IDLE || line_end) ? '0 : h_q + HW'(1);
    ln_d     = last_ln ? '0 : line_end ? ln_q + LW'(1) : ln_q;
    done_d   = state_q == VFP && last_ln;
    if (last_ln)
      state_d = state_q == VSYNC ? VBP : state_q == VBP ? ACTIVE : state_q == ACTIVE ? VFP : state_q;
    if ((state_q == IDLE || done_d) && en) begin
      state_d = VSYNC;
      pat_d   = pattern;
      solid_d = solid_rgb;
    end else if (done_d) begin
      state_d = IDLE;
    end
    bpx_d = bpx_q;
    bar_d = bar_q;
    if (h_d == '0) begin
      bpx_d = '0;
      bar_d = '0;
    end else if (h_q[0]) begin
      bpx_d = bpx_q == BW'(BAR_W-1) ? '0 : bpx_q + BW'(1);
      bar_d = bpx_q == BW'(BAR_W-1) ? bar_q + 3'd1 : bar_q;
    end
    vsync_d = state_q == VSYNC;
    href_d  = state_q == ACTIVE && h_q < HW'(2*H_PX);
    px_d    = href_d ? (h_q[0] ? rgb[7:0] : rgb[15:8]) : '0;
    busy_d  = state_q != IDLE;
    cnt_d   = cnt_q + {7'd0, done_d};
  end
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      ln_q    <= '0;
      bpx_q   <= '0;
      bar_q   <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      px_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      ln_q    <= ln_d;
      bpx_q   <= bpx_d;
      bar_q   <= bar_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      px_q    <= px_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign vid.vsync   = vsync_q;
  assign vid.href    = href_q;
  assign vid.px_data = px_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_cam_emu.sv
// tb_cam_emu: directed checks of cam_emu with a 20-cycle line and 140-cycle frame.
module tb_cam_emu;
  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] solid_rgb = 16'h0;
  logic        busy, frame_done;
  logic [7:0]  frame_cnt;
  int          checks = 0, failures = 0, overlap = 0;
  logic        vs_a [0:299];
  logic        hr_a [0:299];
  logic        dn_a [0:299];
  logic        bz_a [0:299];
  logic [7:0]  px_a [0:299];
  logic [7:0]  cn_a [0:299];
  logic [7:0]  bars_l0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                               8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  cam_emu_if vid();
  cam_emu #(.H_PX(8), .V_LN(4), .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .H_BLANK(4)) dut (
    .pclk(pclk), .rst(rst), .en(en), .pattern(pattern), .solid_rgb(solid_rgb),
    .vid(vid), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Called at a negedge with the DUT idle; c=1 is the first cycle vsync should be high.
  task automatic capture(input int len, input bit hold, input int chg, input logic [1:0] np,
                         input logic [15:0] ns);
    en = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    if (!hold) en = 1'b0;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) @(negedge pclk);
      vs_a[c] = vid.vsync;
      hr_a[c] = vid.href;
      px_a[c] = vid.px_data;
      dn_a[c] = frame_done;
      bz_a[c] = busy;
      cn_a[c] = frame_cnt;
      if (vid.vsync && vid.href) overlap++;
      if (c == chg) begin
        pattern = np;
        solid_rgb = ns;
      end
    end
  endtask
  initial begin
    logic [11:0] exp_v;
    int h, dones, cyc;
    bit seen;
    repeat (3) @(negedge pclk);
    chk("reset_outs", {vid.vsync, vid.href, vid.px_data, busy, frame_done, frame_cnt}, 0);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      chk("idle_outs", {vid.vsync, vid.href, vid.px_data, busy, frame_done, frame_cnt}, 0);
    end
    pattern = 2'd2;
    solid_rgb = 16'hA55A;
    capture(141, 1'b0, -1, 2'd0, 16'h0);
    for (int c = 1; c <= 141; c++) begin
      h = (c - 41) % 20;
      exp_v[11] = c <= 20;
      exp_v[10] = c >= 41 && c <= 120 && h < 16;
      exp_v[9]  = c == 140;
      exp_v[8]  = 1'b0;
      exp_v[7:0] = exp_v[10] ? (h % 2 == 1 ? 8'h5A : 8'hA5) : 8'h00;
      chk($sformatf("solid_c%0d", c), {vs_a[c], hr_a[c], dn_a[c], 1'b0, px_a[c]}, exp_v);
    end
    chk("solid_latency", {vs_a[0], bz_a[0], bz_a[1]}, 3'b001);
    chk("solid_cnt_pre", cn_a[139], 0);
    chk("solid_cnt", cn_a[140], 1);
    chk("solid_busy_end", {bz_a[140], bz_a[141]}, 2'b10);
    pattern = 2'd0;
    capture(141, 1'b0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bars_l0_b%0d", i), px_a[41+i], bars_l0[i]);
      chk($sformatf("bars_l3_b%0d", i), px_a[101+i], bars_l0[i]);
    end
    chk("bars_cnt", cn_a[140], 2);
    pattern = 2'd1;
    capture(141, 1'b0, -1, 2'd0, 16'h0);
    chk("ramp_x0y0", {px_a[41], px_a[42]}, 16'h0000);
    chk("ramp_x2y1", {px_a[65], px_a[66]}, 16'h1023);
    chk("ramp_x7y3", {px_a[115], px_a[116]}, 16'h386A);
    pattern = 2'd3;
    solid_rgb = 16'hBEEF;
    capture(141, 1'b0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("checker_l0_b%0d", i), {hr_a[41+i], px_a[41+i]}, 9'h100);
    pattern = 2'd0;
    capture(290, 1'b1, 60, 2'd2, 16'h1234);
    chk("b2b_f1_bars", {px_a[101], px_a[104]}, 16'hFFE0);
    chk("b2b_done1", {dn_a[140], vs_a[140], vs_a[141], dn_a[141]}, 4'b1010);
    chk("b2b_f2_solid", {px_a[181], px_a[182]}, 16'h1234);
    chk("b2b_done2", {dn_a[280], cn_a[280]}, {1'b1, 8'd6});
    chk("vs_hr_overlap", overlap, 0);
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge pclk);
      if (frame_done) seen = 1;
    end
    chk("stop_after_frame", seen, 1);
    @(negedge pclk);
    chk("idle_after_stop", busy, 0);
    pattern = 2'd2;
    solid_rgb = 16'hA55A;
    capture(86, 1'b1, -1, 2'd0, 16'h0);
    chk("pre_reset_byte", {hr_a[86], px_a[86]}, 9'h15A);
    rst = 1'b0;
    #1;
    chk("mid_reset_outs", {vid.vsync, vid.href, vid.px_data, busy, frame_done, frame_cnt}, 0);
    @(negedge pclk);
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("restart_c0", {vid.vsync, busy}, 2'b00);
    @(negedge pclk);
    chk("restart_c1", {vid.vsync, busy, frame_cnt}, {2'b11, 8'd0});
    repeat (19) @(negedge pclk);
    chk("restart_c20", vid.vsync, 1);
    @(negedge pclk);
    chk("restart_c21", vid.vsync, 0);
    dones = 0;
    cyc = 0;
    while (dones < 256 && cyc < 256*140 + 300) begin
      @(negedge pclk);
      cyc++;
      if (frame_done) begin
        dones++;
        if (dones == 1) chk("wrap_first", frame_cnt, 1);
        if (dones == 255) chk("wrap_255", frame_cnt, 255);
        if (dones == 256) chk("wrap_zero", frame_cnt, 0);
      end
    end
    chk("wrap_frames_seen", dones, 256);
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
